// File: rtl/graph_loader.sv
// graph_loader: turns host node records into mesh packets and collects the final path count.
// Packages parameters/types are kept in this file so the block is self-contained.

package parameters;
  localparam int MAX_NODES_BITS     = 8;
  localparam int MAX_PATHS_BITS     = 16;
  localparam int MAX_EDGES_PER_LOAD = 4;
  localparam int MAX_EDGES_IOO      = 8;
  localparam int NODES_PER_BANK     = 4;
  localparam int MESH_DIMENSION     = 2;
endpackage

package types;
  import parameters::*;

  localparam int NUM_CHILDREN_BITS = $clog2(MAX_EDGES_IOO + 1);
  localparam int NUM_EDGES_BITS    = $clog2(MAX_EDGES_PER_LOAD);

  typedef enum logic [2:0] {
    CTRL_NONE    = 3'd0,
    CTRL_PARENTS = 3'd1,
    CTRL_CONFIG  = 3'd2,
    CTRL_SUM     = 3'd3,
    CTRL_DONE    = 3'd4
  } ctrl_e;

  typedef struct packed {
    logic [MAX_NODES_BITS-1:0] x;
    logic [MAX_NODES_BITS-1:0] y;
    logic [MAX_NODES_BITS-1:0] z;
  } addr_t;

  typedef struct packed {
    logic [MAX_NODES_BITS-1:0] node_id;
  } edge_t;

  typedef struct packed {
    logic                         is_you;
    logic [NUM_CHILDREN_BITS-1:0] num_children;
  } config_t;

  typedef struct packed {
    logic [MAX_PATHS_BITS-1:0] value;
  } path_sum_t;

  typedef struct packed {
    edge_t [MAX_EDGES_PER_LOAD-1:0] edges;
    logic  [NUM_EDGES_BITS-1:0]     num_edges;  // a full batch is encoded as 0
    config_t                        cfg;
    path_sum_t                      sum_t;
  } data_t;

  typedef struct packed {
    ctrl_e ctrl;
    addr_t addr;
    data_t data;
  } pkt_t;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
// The sender holds valid and payload stable until that edge; valid never depends on ready.
module graph_loader
  import parameters::*;
  import types::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         host_valid,
  output logic                         host_ready,
  input  logic                         host_hdr,
  input  logic [MAX_NODES_BITS-1:0]    host_node_id,
  input  logic                         host_is_you,
  input  logic [NUM_CHILDREN_BITS-1:0] host_num_children,
  input  logic                         host_eop,
  input  logic                         host_eol,
  output logic                         valid_out,
  input  logic                         ready_out,
  output pkt_t                         out_pkt,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  pkt_t                         in_pkt,
  output logic                         done,
  output logic [MAX_PATHS_BITS-1:0]    result,
  output logic                         error,
  output logic [2:0]                   dbg_state
);

  localparam int CNT_W = $clog2(MAX_EDGES_PER_LOAD + 1);
  localparam int TOT_W = $clog2(MAX_EDGES_IOO + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_EDGES_PER_LOAD);
  localparam logic [TOT_W-1:0] CAP_TOT  = TOT_W'(MAX_EDGES_IOO);
  localparam logic [MAX_NODES_BITS-1:0] X_SPAN = MAX_NODES_BITS'(NODES_PER_BANK * MESH_DIMENSION);
  localparam logic [MAX_NODES_BITS-1:0] Z_SPAN = MAX_NODES_BITS'(NODES_PER_BANK);
  localparam logic [MAX_NODES_BITS-1:0] Y_SPAN = MAX_NODES_BITS'(MESH_DIMENSION);

  typedef enum logic [2:0] {
    S_HDR          = 3'd0,
    S_COLLECT      = 3'd1,
    S_SEND_PARENTS = 3'd2,
    S_SEND_CONFIG  = 3'd3,
    S_WAIT_DONE    = 3'd4,
    S_FINISHED     = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [MAX_NODES_BITS-1:0]    node_id_q, node_id_d;
  logic                         is_you_q, is_you_d;
  logic [NUM_CHILDREN_BITS-1:0] num_children_q, num_children_d;
  logic                         eol_q, eol_d;
  logic                         eop_seen_q, eop_seen_d;
  logic [MAX_NODES_BITS-1:0]    buf_q [MAX_EDGES_PER_LOAD];
  logic [MAX_NODES_BITS-1:0]    buf_d [MAX_EDGES_PER_LOAD];
  logic [CNT_W-1:0]             count_q, count_d;
  logic [TOT_W-1:0]             total_q, total_d;
  logic                         done_q, done_d;
  logic [MAX_PATHS_BITS-1:0]    result_q, result_d;
  logic                         error_q, error_d;

  logic host_ready_c, valid_out_c, ready_in_c;
  pkt_t pkt_c;

  // Return-port fields that the loader never looks at.
  logic unused_in_bits;
  assign unused_in_bits = ^{in_pkt.addr, in_pkt.data.edges, in_pkt.data.num_edges, in_pkt.data.cfg};

  // State register and all datapath registers; reset discards any partial batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_HDR;
      node_id_q      <= '0;
      is_you_q       <= 1'b0;
      num_children_q <= '0;
      eol_q          <= 1'b0;
      eop_seen_q     <= 1'b0;
      for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) buf_q[i] <= '0;
      count_q        <= '0;
      total_q        <= '0;
      done_q         <= 1'b0;
      result_q       <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      node_id_q      <= node_id_d;
      is_you_q       <= is_you_d;
      num_children_q <= num_children_d;
      eol_q          <= eol_d;
      eop_seen_q     <= eop_seen_d;
      buf_q          <= buf_d;
      count_q        <= count_d;
      total_q        <= total_d;
      done_q         <= done_d;
      result_q       <= result_d;
      error_q        <= error_d;
    end
  end

  // Next-state logic and handshake readiness for the record/packet sequencer.
  always_comb begin
    state_d        = state_q;
    node_id_d      = node_id_q;
    is_you_d       = is_you_q;
    num_children_d = num_children_q;
    eol_d          = eol_q;
    eop_seen_d     = eop_seen_q;
    buf_d          = buf_q;
    count_d        = count_q;
    total_d        = total_q;
    done_d         = done_q;
    result_d       = result_q;
    error_d        = error_q;
    host_ready_c   = 1'b0;
    valid_out_c    = 1'b0;
    ready_in_c     = 1'b0;
    case (state_q)
      S_HDR: begin
        host_ready_c = 1'b1;
        if (host_valid) begin
          if (host_hdr) begin
            node_id_d      = host_node_id;
            is_you_d       = host_is_you;
            num_children_d = host_num_children;
            eol_d          = host_eop & host_eol;
            eop_seen_d     = host_eop;
            count_d        = '0;
            total_d        = '0;
            state_d        = host_eop ? S_SEND_CONFIG : S_COLLECT;
          end else begin
            error_d = 1'b1;  // stray parent beat: consumed and dropped
          end
        end
      end
      S_COLLECT: begin
        host_ready_c = 1'b1;
        if (host_valid) begin
          if (host_hdr) begin
            error_d = 1'b1;  // stray header beat: consumed and dropped
          end else begin
            if (total_q < CAP_TOT) begin
              buf_d[count_q[NUM_EDGES_BITS-1:0]] = host_node_id;
              count_d = count_q + 1'b1;
              total_d = total_q + 1'b1;
            end else begin
              error_d = 1'b1;  // parent beyond the per-node cap
            end
            if (host_eop) begin
              eop_seen_d = 1'b1;
              eol_d      = host_eol;
            end
            // An eop with nothing buffered has no parents left to send.
            if (count_d == FULL_CNT) state_d = S_SEND_PARENTS;
            else if (host_eop) state_d = (count_d == '0) ? S_SEND_CONFIG : S_SEND_PARENTS;
          end
        end
      end
      S_SEND_PARENTS: begin
        valid_out_c = 1'b1;
        if (ready_out) begin
          count_d = '0;
          state_d = eop_seen_q ? S_SEND_CONFIG : S_COLLECT;
        end
      end
      S_SEND_CONFIG: begin
        valid_out_c = 1'b1;
        if (ready_out) state_d = eol_q ? S_WAIT_DONE : S_HDR;
      end
      S_WAIT_DONE: begin
        ready_in_c = 1'b1;
        if (valid_in && (in_pkt.ctrl == CTRL_DONE)) begin
          result_d = in_pkt.data.sum_t.value;
          done_d   = 1'b1;
          state_d  = S_FINISHED;
        end
      end
      S_FINISHED: begin
        done_d = 1'b1;
      end
      default: state_d = S_HDR;
    endcase
  end

  // Outgoing packet: all-zero unless a send state is driving it; content depends only on registers.
  always_comb begin
    pkt_c = '0;
    if ((state_q == S_SEND_PARENTS) || (state_q == S_SEND_CONFIG)) begin
      pkt_c.addr.x = node_id_q / X_SPAN;
      pkt_c.addr.y = (node_id_q / Z_SPAN) % Y_SPAN;
      pkt_c.addr.z = node_id_q % Z_SPAN;
    end
    if (state_q == S_SEND_PARENTS) begin
      pkt_c.ctrl           = CTRL_PARENTS;
      pkt_c.data.num_edges = count_q[NUM_EDGES_BITS-1:0];
      for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) begin
        if (CNT_W'(i) < count_q) pkt_c.data.edges[i].node_id = buf_q[i];
      end
    end
    if (state_q == S_SEND_CONFIG) begin
      pkt_c.ctrl                  = CTRL_CONFIG;
      pkt_c.data.cfg.is_you       = is_you_q;
      pkt_c.data.cfg.num_children = num_children_q;
    end
  end

  assign host_ready = rst_n & host_ready_c;
  assign valid_out  = rst_n & valid_out_c;
  assign ready_in   = rst_n & ready_in_c;
  assign out_pkt    = rst_n ? pkt_c : '0;
  assign done       = done_q;
  assign result     = result_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_graph_loader.sv
// Self-checking bench for graph_loader: scenario tasks plus a packet scoreboard.
module tb_graph_loader;
  import parameters::*;
  import types::*;

  localparam int PW = $bits(pkt_t);
  localparam logic [2:0] ST_HDR       = 3'd0;
  localparam logic [2:0] ST_COLLECT   = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic       host_hdr = 1'b0;
  logic [7:0] host_node_id = '0;
  logic       host_is_you = 1'b0;
  logic [3:0] host_num_children = '0;
  logic       host_eop = 1'b0;
  logic       host_eol = 1'b0;
  logic       valid_out;
  logic       ready_out = 1'b1;
  pkt_t       out_pkt;
  logic       valid_in = 1'b0;
  logic       ready_in;
  pkt_t       in_pkt = '0;
  logic       done;
  logic [15:0] result;
  logic       error;
  logic [2:0] dbg_state;

  logic [PW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  graph_loader dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_hdr(host_hdr),
    .host_node_id(host_node_id), .host_is_you(host_is_you),
    .host_num_children(host_num_children), .host_eop(host_eop), .host_eol(host_eol),
    .valid_out(valid_out), .ready_out(ready_out), .out_pkt(out_pkt),
    .valid_in(valid_in), .ready_in(ready_in), .in_pkt(in_pkt),
    .done(done), .result(result), .error(error), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every mesh handshake pops one expected packet.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pkt_unexpected: got %h, none expected", out_pkt);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (out_pkt !== pkt_t'(e)) begin
          n_bad++;
          $display("FAIL pkt_content: got %h want %h", out_pkt, e);
        end
      end
    end
  end

  function automatic pkt_t mk_cfg(input logic [7:0] x, y, z, input logic is_you, input logic [3:0] nch);
    pkt_t p;
    p = '0;
    p.ctrl = CTRL_CONFIG;
    p.addr.x = x; p.addr.y = y; p.addr.z = z;
    p.data.cfg.is_you = is_you;
    p.data.cfg.num_children = nch;
    return p;
  endfunction

  function automatic pkt_t mk_par(input logic [7:0] x, y, z, input int cnt,
                                  input logic [7:0] e0, e1, e2, e3);
    pkt_t p;
    p = '0;
    p.ctrl = CTRL_PARENTS;
    p.addr.x = x; p.addr.y = y; p.addr.z = z;
    p.data.num_edges = (cnt == 4) ? 2'd0 : 2'(cnt);
    if (cnt > 0) p.data.edges[0].node_id = e0;
    if (cnt > 1) p.data.edges[1].node_id = e1;
    if (cnt > 2) p.data.edges[2].node_id = e2;
    if (cnt > 3) p.data.edges[3].node_id = e3;
    return p;
  endfunction

  // Driver tasks; all start and end at posedge+1.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_beat(input logic hdr, input logic [7:0] id, input logic is_you,
                           input logic [3:0] nch, input logic eop, input logic eol);
    int waited;
    waited = 0;
    host_valid = 1'b1; host_hdr = hdr; host_node_id = id;
    host_is_you = is_you; host_num_children = nch; host_eop = eop; host_eol = eol;
    @(negedge clk);
    while (!host_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!host_ready) begin
      n_bad++;
      $display("FAIL host_beat_timeout: host_ready=%0b after %0d cycles, want 1", host_ready, waited);
    end
    tick();
    host_valid = 1'b0; host_hdr = 1'b0; host_node_id = '0;
    host_is_you = 1'b0; host_num_children = '0; host_eop = 1'b0; host_eol = 1'b0;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d packets still expected, want 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({host_ready, valid_out, ready_in, done, error} !== 5'b0 || out_pkt !== '0 ||
        result !== 16'h0 || dbg_state !== ST_HDR) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%0b vout=%0b rin=%0b done=%0b err=%0b res=%h st=%0d pkt=%h, want all 0",
               host_ready, valid_out, ready_in, done, error, result, dbg_state, out_pkt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({host_ready, valid_out, ready_in, done, error} !== 5'b0 || out_pkt !== '0 || result !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_hold: rdy=%0b vout=%0b rin=%0b done=%0b err=%0b res=%h, want all 0",
               host_ready, valid_out, ready_in, done, error, result);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (host_ready !== 1'b1 || ready_in !== 1'b0 || valid_out !== 1'b0 || dbg_state !== ST_HDR) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%0b rin=%0b vout=%0b st=%0d, want 1 0 0 0",
               host_ready, ready_in, valid_out, dbg_state);
    end
    tick();
  endtask

  task automatic test_leaf();
    exp_q.push_back(mk_cfg(8'd0, 8'd1, 8'd1, 1'b0, 4'd0));
    host_beat(1'b1, 8'd5, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++;
    if (valid_out !== 1'b1 || out_pkt.ctrl !== CTRL_CONFIG || host_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL leaf_latency: vout=%0b ctrl=%0d rdy=%0b, want 1 %0d 0",
               valid_out, out_pkt.ctrl, host_ready, CTRL_CONFIG);
    end
    tick();
    @(negedge clk);
    n_total++;
    if (host_ready !== 1'b1 || valid_out !== 1'b0 || out_pkt !== '0) begin
      n_bad++;
      $display("FAIL leaf_return: rdy=%0b vout=%0b pkt=%h, want 1 0 0", host_ready, valid_out, out_pkt);
    end
    tick();
    wait_drain();
  endtask

  task automatic test_parents_split();
    exp_q.push_back(mk_par(8'd1, 8'd0, 8'd1, 4, 8'd1, 8'd2, 8'd3, 8'd4));
    exp_q.push_back(mk_par(8'd1, 8'd0, 8'd1, 1, 8'd6, 8'd0, 8'd0, 8'd0));
    exp_q.push_back(mk_cfg(8'd1, 8'd0, 8'd1, 1'b0, 4'd3));
    host_beat(1'b1, 8'd9, 1'b0, 4'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) host_beat(1'b0, 8'(i), 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (valid_out !== 1'b1 || out_pkt.ctrl !== CTRL_PARENTS || out_pkt.data.num_edges !== 2'd0) begin
      n_bad++;
      $display("FAIL parents_latency: vout=%0b ctrl=%0d n=%0d, want 1 %0d 0",
               valid_out, out_pkt.ctrl, out_pkt.data.num_edges, CTRL_PARENTS);
    end
    tick();
    host_beat(1'b0, 8'd6, 1'b0, 4'd0, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    pkt_t held;
    held = mk_par(8'd0, 8'd0, 8'd3, 2, 8'd7, 8'd8, 8'd0, 8'd0);
    exp_q.push_back(held);
    exp_q.push_back(mk_cfg(8'd0, 8'd0, 8'd3, 1'b1, 4'd2));
    host_beat(1'b1, 8'd3, 1'b1, 4'd2, 1'b0, 1'b0);
    ready_out = 1'b0;
    host_beat(1'b0, 8'd7, 1'b0, 4'd0, 1'b0, 1'b0);
    host_beat(1'b0, 8'd8, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (valid_out !== 1'b1 || out_pkt !== held || host_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_cycle%0d: vout=%0b rdy=%0b pkt=%h, want 1 0 %h",
                 c, valid_out, host_ready, out_pkt, held);
      end
      tick();
    end
    ready_out = 1'b1;
    wait_drain();
    n_total++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL error_clean: error=%0b, want 0", error);
    end
  endtask

  task automatic test_cap();
    exp_q.push_back(mk_par(8'd1, 8'd1, 8'd0, 4, 8'd20, 8'd21, 8'd22, 8'd23));
    exp_q.push_back(mk_par(8'd1, 8'd1, 8'd0, 4, 8'd24, 8'd25, 8'd26, 8'd27));
    exp_q.push_back(mk_cfg(8'd1, 8'd1, 8'd0, 1'b0, 4'd2));
    host_beat(1'b1, 8'd12, 1'b0, 4'd2, 1'b0, 1'b0);
    for (int i = 20; i <= 29; i++) host_beat(1'b0, 8'(i), 1'b0, 4'd0, (i == 29), 1'b0);
    wait_drain();
    n_total++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL cap_error: error=%0b, want 1", error);
    end
  endtask

  task automatic test_protocol_error();
    apply_reset();
    host_beat(1'b0, 8'd7, 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++;
    if (error !== 1'b1 || dbg_state !== ST_HDR || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_parent: err=%0b st=%0d vout=%0b, want 1 0 0", error, dbg_state, valid_out);
    end
    tick();
    exp_q.push_back(mk_cfg(8'd0, 8'd1, 8'd2, 1'b1, 4'd1));
    host_beat(1'b1, 8'd6, 1'b1, 4'd1, 1'b1, 1'b0);
    wait_drain();
    exp_q.push_back(mk_par(8'd0, 8'd0, 8'd1, 1, 8'd2, 8'd0, 8'd0, 8'd0));
    exp_q.push_back(mk_cfg(8'd0, 8'd0, 8'd1, 1'b0, 4'd0));
    host_beat(1'b1, 8'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    host_beat(1'b1, 8'd9, 1'b1, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    n_total++;
    if (dbg_state !== ST_COLLECT || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_header: st=%0d vout=%0b, want %0d 0", dbg_state, valid_out, ST_COLLECT);
    end
    tick();
    host_beat(1'b0, 8'd2, 1'b0, 4'd0, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    host_beat(1'b1, 8'd10, 1'b0, 4'd0, 1'b0, 1'b0);
    host_beat(1'b0, 8'd11, 1'b0, 4'd0, 1'b0, 1'b0);
    host_beat(1'b0, 8'd12, 1'b0, 4'd0, 1'b0, 1'b0);
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if (valid_out !== 1'b0 || dbg_state !== ST_HDR) begin
        n_bad++;
        $display("FAIL reset_mid_idle%0d: vout=%0b st=%0d, want 0 0", c, valid_out, dbg_state);
      end
      tick();
    end
    exp_q.push_back(mk_cfg(8'd0, 8'd0, 8'd2, 1'b0, 4'd1));
    host_beat(1'b1, 8'd2, 1'b0, 4'd1, 1'b1, 1'b0);
    wait_drain();
    n_total++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_error: error=%0b, want 0", error);
    end
  endtask

  task automatic test_done();
    exp_q.push_back(mk_cfg(8'd1, 8'd1, 8'd3, 1'b1, 4'd0));
    host_beat(1'b1, 8'd15, 1'b1, 4'd0, 1'b1, 1'b1);
    wait_drain();
    @(negedge clk);
    n_total++;
    if (dbg_state !== ST_WAIT_DONE || ready_in !== 1'b1 || host_ready !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_done: st=%0d rin=%0b rdy=%0b done=%0b, want 4 1 0 0",
               dbg_state, ready_in, host_ready, done);
    end
    tick();
    valid_in = 1'b1;
    in_pkt = '0;
    in_pkt.ctrl = CTRL_SUM;
    in_pkt.data.sum_t.value = 16'h0011;
    tick();
    in_pkt.ctrl = CTRL_DONE;
    in_pkt.data.sum_t.value = 16'h002A;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || result !== 16'h0 || ready_in !== 1'b1) begin
      n_bad++;
      $display("FAIL sum_ignored: done=%0b res=%h rin=%0b, want 0 0000 1", done, result, ready_in);
    end
    tick();
    valid_in = 1'b0;
    in_pkt = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (done !== 1'b1 || result !== 16'h002A || ready_in !== 1'b0 || host_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL finished%0d: done=%0b res=%h rin=%0b rdy=%0b, want 1 002a 0 0",
                 c, done, result, ready_in, host_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_leaf();
    test_parents_split();
    test_backpressure();
    test_cap();
    test_protocol_error();
    test_reset_mid();
    test_done();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/graph_loader.md
GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 Parameters come from package parameters: MAX_NODES_BITS, MAX_PATHS_BITS, MAX_EDGES_PER_LOAD, MAX_EDGES_IOO, NODES_PER_BANK, MESH_DIMENSION; packet types come from package types.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 host_valid / host_ready  in / out  1 each  host record-beat handshake.
REQ-005 host_hdr  in  1  1 = header beat, 0 = parent beat.
REQ-006 host_node_id  in  MAX_NODES_BITS  header: target node id; parent beat: parent id.
REQ-007 host_is_you, host_num_children  in  1, config_t.num_children width  header-only fields.
REQ-008 host_eop, host_eol  in  1 each  last beat of this node / last node of graph (eol sampled only with eop).
REQ-009 valid_out / ready_out / out_pkt  out / in / pkt_t  mesh injection port.
REQ-010 valid_in / ready_in / in_pkt  in / out / pkt_t  mesh return port.
REQ-011 done, result[MAX_PATHS_BITS], error  out  completion, path count, sticky protocol error.

Function
REQ-012 States: HDR, COLLECT, SEND_PARENTS, SEND_CONFIG, WAIT_DONE, FINISHED.
REQ-013 HDR: host_ready=1; header beat latches node_id, is_you, num_children, eol; eop=1 -> SEND_CONFIG, else -> COLLECT.
REQ-014 COLLECT: host_ready=1; each parent beat appends its id to a MAX_EDGES_PER_LOAD-entry buffer, count+1.
REQ-015 Buffer becoming full, or eop on a parent beat, -> SEND_PARENTS on the next cycle.
REQ-016 SEND_PARENTS: valid_out=1, host_ready=0; ctrl=CTRL_PARENTS; edges[i].node_id = buffer[i] for i<count; num_edges = count, with count==MAX_EDGES_PER_LOAD encoded as 0.
REQ-017 SEND_PARENTS on handshake: clear count; -> SEND_CONFIG if eop was seen, else COLLECT.
REQ-018 All CTRL_PARENTS packets for a node are emitted before its CTRL_CONFIG; a leaf node leaves its wait state on config.
REQ-019 SEND_CONFIG: valid_out=1; ctrl=CTRL_CONFIG; config_t fields from the latched header.
REQ-020 SEND_CONFIG on handshake: -> WAIT_DONE if latched eol, else HDR.
REQ-021 Address for every packet: x = id/(NODES_PER_BANK*MESH_DIMENSION), y = (id/NODES_PER_BANK)%MESH_DIMENSION, z = id%NODES_PER_BANK, using the latched header node id.
REQ-022 out_pkt is fully zero whenever valid_out=0; out_pkt and valid_out stay stable while ready_out=0.
REQ-023 WAIT_DONE: ready_in=1; valid_in with ctrl==CTRL_DONE latches data.sum_t.value into result; done=1 -> FINISHED. Any other ctrl is consumed and ignored.
REQ-024 FINISHED: done=1, result held, host_ready=0, ready_in=0 until reset.
REQ-025 ready_in=0 in all states except WAIT_DONE.
REQ-026 Per-node parent total is capped at MAX_EDGES_IOO. Beats beyond the cap are consumed but not forwarded, and set error.
REQ-027 A header beat in COLLECT, or a parent beat in HDR, is consumed and dropped, sets error, and causes no state change.
REQ-028 Latency: eop header beat accepted in cycle N -> CONFIG valid_out in cycle N+1. Filling/eop parent beat in cycle N -> PARENTS valid_out in cycle N+1.

Reset
REQ-029 rst_n low: immediately state=HDR, count=0, done=0, result=0, error=0, and all latched header fields 0.
REQ-030 rst_n low: valid_out, host_ready and ready_in are 0 combinationally; out_pkt is all zero.
REQ-031 Reset mid-packet discards any partial batch. After release, the first accepted beat is treated as a header.

Verification (MAX_EDGES_PER_LOAD=4, NODES_PER_BANK=4, MESH_DIMENSION=2)
REQ-032 Header id=5, children=0, eop=1, eol=0 -> one CONFIG to x=0,y=1,z=1, num_children=0; host_ready=1 in the cycle after the handshake.
REQ-033 Header id=9 plus parents 1,2,3,4,6 (eop on 6) -> PARENTS num_edges=0 {1,2,3,4}, then PARENTS num_edges=1 {6}, then CONFIG, all to x=1,y=0,z=1.
REQ-034 ready_out held low 3 cycles during SEND_PARENTS -> out_pkt stable, no host beat accepted, no packet lost or duplicated.
REQ-035 Last node eol=1, then in_pkt CTRL_SUM followed by CTRL_DONE value=0x2A -> SUM ignored; done=1, result=0x2A held.
REQ-036 Parent beat as first beat after reset -> error=1, beat dropped; next header processed normally.
REQ-037 rst_n pulsed low during COLLECT with 2 buffered parents -> no PARENTS packet is ever emitted for them; outputs at reset values.
